branch_predictor: RTL

- Branch prediction and resolution unit for the 5-stage RISC-V pipeline.
- IF stage: looks up a direct-mapped BTB with 2-bit saturating counters and supplies the predicted next PC.
- ID stage: consumes the branch comparator's taken result plus the computed target, detects mispredictions, drives the flush/redirect, and trains the table.
- Also keeps branch and mispredict performance counters.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_ctr.sv | 22 ++
 rtl/branch_predictor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, the reset and
// allocate values, and the tag-width helper.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    // Word-aligned PCs: the two low bits are neither index nor tag.
    function automatic int tag_width(input int xlen, input int idx_w);
        return xlen - idx_w - 2;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state logic used on the BTB training path.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr_next
);

    // Step towards strongly-taken or strongly-not-taken, holding at either end.
    always_comb begin
        o_ctr_next = i_ctr;
        case (i_ctr)
            SNT:     o_ctr_next = i_taken ? WNT : SNT;
            WNT:     o_ctr_next = i_taken ? WT  : SNT;
            WT:      o_ctr_next = i_taken ? ST  : WNT;
            ST:      o_ctr_next = i_taken ? ST  : WT;
            default: o_ctr_next = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage prediction, ID-stage
// misprediction detection/redirect, table training and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            id_valid,
    input  logic            id_stall,
    input  logic            id_is_branch,
    input  logic            id_is_jal,
    input  logic            id_taken,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_target,
    input  logic            id_pred_taken,
    input  logic [XLEN-1:0] id_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = tag_width(XLEN, IDX_W);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    ctr_e             r_ctr    [ENTRIES];
    logic [31:0]      r_branch_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [XLEN-1:0]  w_if_pc_plus4;
    logic [IDX_W-1:0] w_id_idx;
    logic [TAG_W-1:0] w_id_tag;
    logic             w_id_hit;
    logic             w_res;
    logic             w_act;
    logic [XLEN-1:0]  w_correct_pc;
    logic             w_mispredict;
    ctr_e             w_ctr_next;
    logic             w_unused;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_if_tag      = if_pc[XLEN-1:IDX_W+2];
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_pc_plus4 = if_pc + PC_STEP;

    assign w_id_idx = id_pc[IDX_W+1:2];
    assign w_id_tag = id_pc[XLEN-1:IDX_W+2];
    assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    // A stalled instruction resolves only in its last ID cycle; JAL wins if both flags are set.
    assign w_res        = id_valid && !id_stall && (id_is_branch || id_is_jal);
    assign w_act        = id_is_jal ? 1'b1 : id_taken;
    assign w_correct_pc = w_act ? id_target : (id_pc + PC_STEP);
    assign w_mispredict = w_res && ((w_act != id_pred_taken) ||
                                    (w_act && (id_target != id_pred_target)));

    assign w_unused = ^{if_pc[1:0], id_pc[1:0]};

    bp_sat_ctr u_sat_ctr (
        .i_ctr      (r_ctr[w_id_idx]),
        .i_taken    (w_act),
        .o_ctr_next (w_ctr_next)
    );

    // IF prediction and ID redirect; reset forces the fall-through view.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = w_if_pc_plus4;
        mispredict  = 1'b0;
        redirect_pc = {XLEN{1'b0}};
        if (rst) begin
            pred_taken  = 1'b0;
            pred_target = w_if_pc_plus4;
        end else begin
            pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
            pred_target = (w_if_hit && r_ctr[w_if_idx][1]) ? r_target[w_if_idx] : w_if_pc_plus4;
            mispredict  = w_mispredict;
            redirect_pc = w_mispredict ? w_correct_pc : {XLEN{1'b0}};
        end
    end

    // Table training on resolve; IF reads the pre-update entry this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= {TAG_W{1'b0}};
                r_target[i] <= {XLEN{1'b0}};
                r_ctr[i]    <= CTR_RESET;
            end
        end else if (w_res) begin
            if (w_id_hit) begin
                if (id_is_jal) begin
                    r_ctr[w_id_idx]    <= ST;
                    r_target[w_id_idx] <= id_target;
                end else begin
                    r_ctr[w_id_idx] <= w_ctr_next;
                    if (w_act) begin
                        r_target[w_id_idx] <= id_target;
                    end else begin
                        r_target[w_id_idx] <= r_target[w_id_idx];
                    end
                end
            end else if (w_act) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= id_target;
                r_ctr[w_id_idx]    <= id_is_jal ? ST : CTR_ALLOC;
            end else begin
                r_valid[w_id_idx] <= r_valid[w_id_idx];
            end
        end else begin
            r_valid[w_id_idx] <= r_valid[w_id_idx];
        end
    end

    // Performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            r_branch_cnt  <= r_branch_cnt + {31'd0, w_res};
            r_mispred_cnt <= r_mispred_cnt + {31'd0, w_mispredict};
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
